afe_clk_gen: RTL and testbench
==============================

# afe_clk_gen

Emulated-time clock generator for the AFE example. Consumes the low/high phase durations (`tlo`, `thi`) driven by the simulation controller and produces the emulated sampling clock. Each emulator cycle it requests a timestep equal to the time left until its next edge. It then advances by the timestep the emulator grants. It sits between the simulation controller and the AFE sampler/comparator blocks that are clocked by the emulated clock.

## Interface
Parameters:
- `DT_WIDTH`, 32: width of all time quantities. These are unsigned integers in emulator time LSBs, with 1 LSB = 0.5 ps in the AFE build.
- `CNT_WIDTH`, 32: width of the rising-edge counter.

Ports:
- `emu_clk`, input, 1: emulator clock.
- `emu_rst`, input, 1: reset, synchronous, active-high.
- `en`, input, 1: run enable. When low, generator state is frozen.
- `tlo`, input, `DT_WIDTH`: duration of the low phase.
- `thi`, input, `DT_WIDTH`: duration of the high phase.
- `emu_dt`, input, `DT_WIDTH`: timestep granted for the current cycle.
- `dt_req`, output, `DT_WIDTH`: requested timestep, i.e. time remaining to the next edge.
- `clk_val`, output, 1: emulated clock level.
- `edge_rise`, output, 1: one-cycle pulse coincident with `clk_val` going 0→1.
- `edge_fall`, output, 1: one-cycle pulse coincident with `clk_val` going 1→0.
- `cycle_count`, output, `CNT_WIDTH`: number of rising edges since reset.
- `err_overrun`, output, 1: sticky flag, set when a granted step exceeds the remaining time.

## Operation
- State machine with two states:
  - LOW: `clk_val`=0.
  - HIGH: `clk_val`=1.
- Internal register `rem` holds the time to the next edge.
- Effective duration: `dur(x) = (x == 0) ? 1 : x`. A zero duration is clamped to 1 LSB.
- `dt_req` output:
  - `en`=1: `dt_req` = `rem`.
  - `en`=0: `dt_req` = all ones, placing no constraint on the emulator timestep.
- Per cycle, when `en`=1 and not in reset:
  - `emu_dt` = 0: no change.
  - 0 < `emu_dt` < `rem`: `rem` ← `rem` − `emu_dt`; state unchanged.
  - `emu_dt` ≥ `rem`: edge occurs.
    - State toggles.
    - `rem` ← dur(`thi`) when entering HIGH, or dur(`tlo`) when entering LOW.
    - Edge pulse asserted.
    - Entering HIGH increments `cycle_count`, which wraps modulo 2^`CNT_WIDTH`.
  - `emu_dt` > `rem`: edge handled as above, the excess is discarded (not carried into the next phase), and `err_overrun` is set.
- When `en`=0, all state holds: `rem`, `clk_val`, `cycle_count` and `err_overrun`. Edge pulses are 0.
- `tlo`/`thi` are sampled only at reset and at edges. A change mid-phase takes effect on the next phase of that type.
- At most one edge per emulator cycle, regardless of `emu_dt` size.

## Timing
- Reset (`emu_rst`=1 at an `emu_clk` rising edge) sets:
  - state = LOW, `clk_val`=0;
  - `rem` ← dur(`tlo`);
  - `cycle_count`=0, `err_overrun`=0, `edge_rise`=`edge_fall`=0.
  - `dt_req` is then dur(`tlo`), or all ones if `en`=0.
- Reset asserted mid-phase overrides any pending edge in the same cycle.
- All outputs are registered, except `dt_req`, which is a mux of registered `rem` and `en`.
- `emu_dt` is combinationally derived from `dt_req` in the same cycle by the emulator's timestep minimiser. This block must not add a path from `emu_dt` to `dt_req`.
- Update latency:
  - An edge decided in cycle N appears on `clk_val` and the edge pulses in cycle N+1.
  - `dt_req` shows the new phase duration in cycle N+1.
- `err_overrun` is set in cycle N+1 after an overrun, and is cleared only by reset.

## Test plan
- Reset, `tlo`=`thi`=125, `en`=1, `emu_dt` = `dt_req` every cycle. Expected:
  - `clk_val` toggles every cycle and `dt_req` stays 125;
  - `edge_rise`/`edge_fall` alternate;
  - `cycle_count`=4 after 8 cycles;
  - `err_overrun`=0.
- `tlo`=`thi`=125, `emu_dt` fixed at 62. Expected:
  - `dt_req` sequence 125, 63, 1, then an edge and 125 again;
  - one edge every 3 cycles; no overrun.
- `tlo`=40, `thi`=100, `emu_dt` = `dt_req`. Expected: low for 1 cycle with `dt_req`=40, then high with `dt_req`=100, alternating; duty tracked in time, not cycles.
- Overrun: `rem`=10, force `emu_dt`=25. Expected: edge next cycle, `rem` = new phase duration (not reduced by 15), `err_overrun`=1 held until reset.
- `en`=0 for 5 cycles mid-phase with `rem`=50 and arbitrary `emu_dt`. Expected: `dt_req`=all ones, no state change, no pulses; on `en`=1, `dt_req`=50.
- `thi`=0. Expected: high phase lasts 1 LSB (`dt_req`=1). Separately, asserting `emu_rst` in a cycle where `emu_dt` ≥ `rem` gives LOW, `cycle_count`=0, and no edge pulse.

Source files
------------

// File: rtl/afe_clk_gen.sv
// afe_clk_gen: emulated-time clock generator that turns granted timesteps into clock edges
module afe_clk_gen #(
  parameter int DT_WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic                 en,
  input  logic [DT_WIDTH-1:0]  tlo,
  input  logic [DT_WIDTH-1:0]  thi,
  input  logic [DT_WIDTH-1:0]  emu_dt,
  output logic [DT_WIDTH-1:0]  dt_req,
  output logic                 clk_val,
  output logic                 edge_rise,
  output logic                 edge_fall,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 err_overrun
);
  typedef enum logic {LOW, HIGH} state_t;
  state_t state;
  logic [DT_WIDTH-1:0] rem;
  function automatic logic [DT_WIDTH-1:0] dur(input logic [DT_WIDTH-1:0] x);
    return (x == '0) ? DT_WIDTH'(1) : x;
  endfunction
  assign dt_req = en ? rem : '1;
  assign clk_val = (state == HIGH);
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state <= LOW;
      rem <= dur(tlo);
      cycle_count <= '0;
      err_overrun <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
    end else begin
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
      if (en && emu_dt != '0) begin
        if (emu_dt >= rem) begin
          state <= (state == LOW) ? HIGH : LOW;
          rem <= dur((state == LOW) ? thi : tlo);
          edge_rise <= (state == LOW);
          edge_fall <= (state == HIGH);
          if (state == LOW) cycle_count <= cycle_count + CNT_WIDTH'(1);
          if (emu_dt > rem) err_overrun <= 1'b1;
        end else begin
          rem <= rem - emu_dt;
        end
      end
    end
  end
endmodule

// File: tb/tb_afe_clk_gen.sv
// tb_afe_clk_gen: scoreboard bench with an absolute-time reference model
module tb_afe_clk_gen;
  localparam int W = 32;
  logic emu_clk = 1'b0;
  logic emu_rst = 1'b1;
  logic en = 1'b0;
  logic [W-1:0] tlo = '0, thi = '0, emu_dt = '0;
  logic [W-1:0] dt_req, cycle_count;
  logic clk_val, edge_rise, edge_fall, err_overrun;

  afe_clk_gen #(.DT_WIDTH(W), .CNT_WIDTH(W)) dut (
    .emu_clk(emu_clk), .emu_rst(emu_rst), .en(en), .tlo(tlo), .thi(thi),
    .emu_dt(emu_dt), .dt_req(dt_req), .clk_val(clk_val), .edge_rise(edge_rise),
    .edge_fall(edge_fall), .cycle_count(cycle_count), .err_overrun(err_overrun)
  );

  always #5 emu_clk = ~emu_clk;

  typedef struct packed {
    logic [W-1:0] dt;
    logic clk, rise, fall;
    logic [W-1:0] cnt;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int checks = 0, errors = 0;

  // model keeps absolute emulated time and the absolute time of the next edge
  longint unsigned now_t = 0, nxt_t = 0;
  bit lvl, m_rise, m_fall, m_err, inited;
  int unsigned m_cnt;

  function automatic logic [W-1:0] dur(input logic [W-1:0] x);
    return (x == 0) ? W'(1) : x;
  endfunction

  function automatic logic [W-1:0] m_rem();
    return W'(nxt_t - now_t);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge emu_clk) begin
    if (q.size() > 0) begin
      e_m = q.pop_front();
      chk("dt_req", dt_req, e_m.dt);
      chk("clk_val", W'(clk_val), W'(e_m.clk));
      chk("edge_rise", W'(edge_rise), W'(e_m.rise));
      chk("edge_fall", W'(edge_fall), W'(e_m.fall));
      chk("cycle_count", cycle_count, e_m.cnt);
      chk("err_overrun", W'(err_overrun), W'(e_m.err));
    end
  end

  // mode 0: emu_dt=v, 1: emu_dt=remaining time, 2: remaining time plus v
  task automatic cyc(input bit r, input bit e, input logic [W-1:0] lo, input logic [W-1:0] hi,
                     input int mode, input logic [W-1:0] v);
    logic [W-1:0] d;
    d = (mode == 0) ? v : (mode == 1) ? m_rem() : m_rem() + v;
    emu_rst = r; en = e; tlo = lo; thi = hi; emu_dt = d;
    if (inited)
      q.push_back('{dt: e ? m_rem() : '1, clk: lvl, rise: m_rise, fall: m_fall,
                    cnt: W'(m_cnt), err: m_err});
    @(posedge emu_clk);
    #1;
    if (r) begin
      inited = 1; lvl = 0; now_t = 0; nxt_t = dur(lo);
      m_cnt = 0; m_err = 0; m_rise = 0; m_fall = 0;
    end else begin
      m_rise = 0; m_fall = 0;
      if (e && d != 0) begin
        now_t += d;
        if (now_t >= nxt_t) begin
          if (now_t > nxt_t) m_err = 1;
          lvl = !lvl;
          m_rise = lvl;
          m_fall = !lvl;
          if (lvl) m_cnt++;
          nxt_t = now_t + dur(lvl ? hi : lo);
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] lo, hi, d;
    bit r, e;
    int k;
    cyc(1, 1, 125, 125, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 125, 125, 1, 0);
    chk("cnt_after_8", cycle_count, 4);
    chk("no_overrun", W'(err_overrun), 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 125, 125, 0, 62);
    cyc(1, 1, 40, 100, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 40, 100, 1, 0);
    cyc(1, 1, 10, 10, 0, 0);
    cyc(0, 1, 10, 10, 0, 25);
    chk("overrun_flag", W'(err_overrun), 1);
    chk("overrun_rem", dt_req, 10);
    for (int i = 0; i < 4; i++) cyc(0, 1, 10, 10, 0, 3);
    chk("overrun_sticky", W'(err_overrun), 1);
    cyc(1, 1, 100, 100, 0, 0);
    chk("overrun_cleared", W'(err_overrun), 0);
    cyc(0, 1, 100, 100, 0, 50);
    for (int i = 0; i < 5; i++) cyc(0, 0, 100, 100, 0, $urandom);
    chk("dis_dt_req", dt_req, '1);
    cyc(0, 1, 100, 100, 0, 0);
    chk("en_dt_req", dt_req, 50);
    cyc(1, 1, 5, 0, 0, 0);
    cyc(0, 1, 5, 0, 1, 0);
    chk("thi_zero", dt_req, 1);
    cyc(0, 1, 5, 0, 1, 0);
    cyc(0, 1, 5, 0, 1, 0);
    cyc(1, 1, 5, 0, 1, 0);
    chk("rst_edge_clk", W'(clk_val), 0);
    chk("rst_edge_cnt", cycle_count, 0);
    chk("rst_edge_rise", W'(edge_rise), 0);
    lo = 125; hi = 125;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) lo = $urandom_range(0, 200);
      if ($urandom_range(0, 7) == 0) hi = $urandom_range(0, 200);
      k = $urandom_range(0, 9);
      d = (k == 0) ? 0 : (k <= 5) ? W'($urandom_range(1, m_rem())) :
          (k <= 7) ? m_rem() : (k == 8) ? m_rem() + W'($urandom_range(1, 50)) : W'($urandom);
      cyc(r, e, lo, hi, 0, d);
    end
    repeat (2) @(negedge emu_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
